// File: rtl/ysyx_24090012_mem_arb.sv
// Two-requester (IFU/LSU) arbiter serialising transactions onto a single memory port.
// Build option MEM_ARB_RR_EN: round-robin tie-break; otherwise LSU wins ties.
//
//  state  | meaning
//  S_IDLE | no transaction; combinational arbitration, winner's req_ready=1
//  S_REQ  | mem_req_valid=1 with registered fields, waiting for mem_req_ready
//  S_RESP | response passed through to the granted requester
module ysyx_24090012_mem_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   input  logic                ifu_resp_ready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic                ifu_resp_err,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   input  logic                lsu_resp_ready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_resp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   output logic                mem_resp_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_resp_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   grant_q;   // 0 = IFU, 1 = LSU
   logic   tie_lsu;
   logic   pick_lsu;
   logic   resp_fire;

`ifdef MEM_ARB_RR_EN
   logic   last_grant_q;

   // The requester that was not served last wins a tie.
   assign tie_lsu = (last_grant_q == 1'b0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q <= 1'b1;
      end else if (resp_fire) begin
         last_grant_q <= grant_q;
      end
   end
`else
   assign tie_lsu = 1'b1;
`endif

   assign pick_lsu  = lsu_req_valid & (~ifu_req_valid | tie_lsu);
   assign resp_fire = (state_q == S_RESP) & mem_resp_valid & mem_resp_ready;

   assign ifu_rdata = mem_rdata;
   assign lsu_rdata = mem_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      mem_req_valid  = 1'b0;
      mem_resp_ready = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      ifu_resp_err   = 1'b0;
      lsu_resp_err   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Gated by rst so nothing is offered while reset is held.
            ifu_req_ready = rst & ifu_req_valid & ~pick_lsu;
            lsu_req_ready = rst & pick_lsu;
            if (ifu_req_ready || lsu_req_ready) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (grant_q) begin
               mem_resp_ready = lsu_resp_ready;
               lsu_resp_valid = mem_resp_valid;
               lsu_resp_err   = mem_resp_err;
            end else begin
               mem_resp_ready = ifu_resp_ready;
               ifu_resp_valid = mem_resp_valid;
               ifu_resp_err   = mem_resp_err;
            end
            if (mem_resp_valid && mem_resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_q   <= 1'b0;
         mem_addr  <= '0;
         mem_wen   <= 1'b0;
         mem_wdata <= '0;
         mem_wmask <= '0;
      end else if (lsu_req_ready) begin
         grant_q   <= 1'b1;
         mem_addr  <= lsu_addr;
         mem_wen   <= lsu_wen;
         mem_wdata <= lsu_wdata;
         mem_wmask <= lsu_wmask;
      end else if (ifu_req_ready) begin
         grant_q   <= 1'b0;
         mem_addr  <= ifu_addr;
         mem_wen   <= 1'b0;
         mem_wdata <= '0;
         mem_wmask <= '0;
      end
   end

endmodule
